// File: rtl/ogpu_quad_store_mailbox_if.sv
// Quad-store ingress and Avalon-MM slave bundle for the store mailbox.
interface ogpu_quad_store_mailbox_if;
  logic        st_valid;
  logic        st_ready;
  logic [31:0] st_addr;
  logic [63:0] st_data;
  logic [1:0]  address;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        irq;

  modport master (
    output st_valid, st_addr, st_data, address, read, write, writedata,
    input  st_ready, readdata, irq
  );

  modport slave (
    input  st_valid, st_addr, st_data, address, read, write, writedata,
    output st_ready, readdata, irq
  );
endinterface

// File: rtl/ogpu_quad_store_mailbox.sv
// Lossless FIFO of quad-store results {addr, data} drained by the HPS over an
// Avalon-MM slave with 1-cycle registered readdata and a level interrupt.
module ogpu_quad_store_mailbox #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned CNT_W = $clog2(DEPTH) + 1
) (
  input  logic                        clk,
  input  logic                        reset_n,
  ogpu_quad_store_mailbox_if.slave    bus
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             irq_en;
  logic [31:0]      readdata_q;
  logic             irq_q;

  logic [95:0]      mem [DEPTH];
  logic [95:0]      head;
  logic             full;
  logic             nonempty;
  logic             push;
  logic             pop;
  logic             ctrl_wr;
  logic [31:0]      status;
  logic [31:0]      readdata_d;
  logic             unused_read;

  assign unused_read = bus.read;

  assign full     = (count == CNT_W'(DEPTH));
  assign nonempty = (count != '0);

  // Ready depends only on the registered count, so a pop while full cannot
  // admit a push in the same cycle.
  assign bus.st_ready = !full;
  assign push         = bus.st_valid && !full;
  assign ctrl_wr      = bus.write && (bus.address == 2'd3);
  assign pop          = ctrl_wr && bus.writedata[0] && nonempty;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {bus.st_addr, bus.st_data};
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      irq_en <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      if (ctrl_wr) begin
        irq_en <= bus.writedata[1];
      end
    end
  end

  assign head = mem[rd_ptr];

  always_comb begin
    status       = '0;
    status[0]    = nonempty;
    status[1]    = full;
    status[2]    = irq_en;
    status[15:8] = 8'(count);
  end

  always_comb begin
    readdata_d = '0;
    case (bus.address)
      2'd0:    readdata_d = nonempty ? head[31:0]  : '0;
      2'd1:    readdata_d = nonempty ? head[63:32] : '0;
      2'd2:    readdata_d = nonempty ? head[95:64] : '0;
      default: readdata_d = status;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata_q <= '0;
      irq_q      <= 1'b0;
    end else begin
      readdata_q <= readdata_d;
      irq_q      <= irq_en && nonempty;
    end
  end

  assign bus.readdata = readdata_q;
  assign bus.irq      = irq_q;

endmodule

// File: tb/tb_ogpu_quad_store_mailbox.sv
// Self-checking bench for ogpu_quad_store_mailbox against a queue-based model.
module tb_ogpu_quad_store_mailbox;

  localparam int unsigned DEPTH = 8;

  logic clk;
  logic reset_n;

  ogpu_quad_store_mailbox_if bus ();

  ogpu_quad_store_mailbox #(.DEPTH(DEPTH)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [95:0] q[$];
  logic        m_irq_en = 1'b0;

  function automatic logic [31:0] exp_reg(input logic [1:0] a);
    logic [31:0] s;
    logic [95:0] h;
    if (a == 2'd3) begin
      s       = '0;
      s[0]    = (q.size() != 0);
      s[1]    = (q.size() == DEPTH);
      s[2]    = m_irq_en;
      s[15:8] = 8'(q.size());
      return s;
    end
    if (q.size() == 0) return 32'h0;
    h = q[0];
    case (a)
      2'd0:    return h[31:0];
      2'd1:    return h[63:32];
      default: return h[95:64];
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_bus();
    bus.st_valid  = 1'b0;
    bus.st_addr   = '0;
    bus.st_data   = '0;
    bus.address   = 2'd0;
    bus.read      = 1'b0;
    bus.write     = 1'b0;
    bus.writedata = '0;
  endtask

  task automatic push(input logic [31:0] a, input logic [63:0] d);
    bus.st_valid = 1'b1;
    bus.st_addr  = a;
    bus.st_data  = d;
    if (q.size() != DEPTH) q.push_back({a, d});
    tick();
    bus.st_valid = 1'b0;
  endtask

  task automatic ctrl_write(input logic [31:0] wd);
    bus.address   = 2'd3;
    bus.write     = 1'b1;
    bus.writedata = wd;
    if (wd[0] && q.size() != 0) void'(q.pop_front());
    m_irq_en = wd[1];
    tick();
    bus.write = 1'b0;
  endtask

  task automatic pop();
    ctrl_write({30'h0, m_irq_en, 1'b1});
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    bus.address = a;
    bus.read    = 1'b1;
    tick();
    bus.read = 1'b0;
    d = bus.readdata;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    reset_n = 1'b0;
    idle_bus();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (bus.readdata !== 32'h0 || bus.irq !== 1'b0) begin
      errors++;
      $display("FAIL reset_hold readdata=%h irq=%b required 0/0", bus.readdata, bus.irq);
    end
    reset_n = 1'b1;
    q.delete();
    m_irq_en = 1'b0;
    tick();
    rd(2'd3, d);
    checks++;
    if (d !== 32'h0) begin
      errors++;
      $display("FAIL reset_status actual=%h required=00000000", d);
    end
    checks++;
    if (bus.st_ready !== 1'b1 || bus.irq !== 1'b0) begin
      errors++;
      $display("FAIL reset_ready_irq st_ready=%b irq=%b required 1/0", bus.st_ready, bus.irq);
    end
  endtask

  task automatic test_single();
    logic [31:0] d;
    logic [31:0] req [4];
    req[0] = 32'hCAFEF00D;
    req[1] = 32'hDEADBEEF;
    req[2] = 32'h10000040;
    req[3] = 32'h00000101;
    push(32'h1000_0040, 64'hDEADBEEF_CAFEF00D);
    for (int i = 0; i < 4; i++) begin
      rd(2'(i), d);
      checks++;
      if (d !== req[i]) begin
        errors++;
        $display("FAIL single_addr%0d actual=%h required=%h", i, d, req[i]);
      end
    end
    pop();
  endtask

  task automatic test_full();
    logic [31:0] d;
    logic [31:0] a9;
    logic [63:0] d9;
    for (int i = 0; i < DEPTH; i++) push($urandom, {$urandom, $urandom});
    rd(2'd3, d);
    checks++;
    if (d !== 32'h0000_0803 || bus.st_ready !== 1'b0) begin
      errors++;
      $display("FAIL full_status status=%h st_ready=%b required 00000803/0", d, bus.st_ready);
    end
    a9 = $urandom;
    d9 = {$urandom, $urandom};
    bus.st_valid = 1'b1;
    bus.st_addr  = a9;
    bus.st_data  = d9;
    repeat (3) tick();
    rd(2'd3, d);
    checks++;
    if (d !== 32'h0000_0803 || bus.st_ready !== 1'b0) begin
      errors++;
      $display("FAIL full_stall status=%h st_ready=%b required 00000803/0", d, bus.st_ready);
    end
    pop();
    checks++;
    if (bus.st_ready !== 1'b1) begin
      errors++;
      $display("FAIL full_ready_after_pop actual=%b required=1", bus.st_ready);
    end
    q.push_back({a9, d9});
    tick();
    bus.st_valid = 1'b0;
    rd(2'd3, d);
    checks++;
    if (d !== exp_reg(2'd3)) begin
      errors++;
      $display("FAIL full_ninth_accept status=%h required=%h", d, exp_reg(2'd3));
    end
    while (q.size() != 0) begin
      for (int a = 0; a < 3; a++) begin
        rd(2'(a), d);
        checks++;
        if (d !== exp_reg(2'(a))) begin
          errors++;
          $display("FAIL full_drain_addr%0d actual=%h required=%h", a, d, exp_reg(2'(a)));
        end
      end
      pop();
    end
  endtask

  task automatic test_empty_pop();
    logic [31:0] d;
    pop();
    pop();
    rd(2'd3, d);
    checks++;
    if (d !== 32'h0) begin
      errors++;
      $display("FAIL empty_pop_status actual=%h required=00000000", d);
    end
    push(32'hA5A5_0000, 64'h0123_4567_89AB_CDEF);
    for (int a = 0; a < 4; a++) begin
      rd(2'(a), d);
      checks++;
      if (d !== exp_reg(2'(a))) begin
        errors++;
        $display("FAIL empty_pop_read%0d actual=%h required=%h", a, d, exp_reg(2'(a)));
      end
    end
    pop();
  endtask

  task automatic test_irq();
    ctrl_write(32'h2);
    repeat (2) tick();
    checks++;
    if (bus.irq !== 1'b0) begin
      errors++;
      $display("FAIL irq_empty actual=%b required=0", bus.irq);
    end
    push($urandom, {$urandom, $urandom});
    checks++;
    if (bus.irq !== 1'b0) begin
      errors++;
      $display("FAIL irq_lag actual=%b required=0", bus.irq);
    end
    tick();
    checks++;
    if (bus.irq !== 1'b1) begin
      errors++;
      $display("FAIL irq_assert actual=%b required=1", bus.irq);
    end
    pop();
    tick();
    checks++;
    if (bus.irq !== 1'b0) begin
      errors++;
      $display("FAIL irq_deassert actual=%b required=0", bus.irq);
    end
    ctrl_write(32'h0);
  endtask

  task automatic test_back_to_back();
    logic [31:0] e;
    logic [31:0] d;
    for (int i = 0; i < 3; i++) push($urandom, {$urandom, $urandom});
    bus.address   = 2'd3;
    bus.write     = 1'b1;
    bus.writedata = {30'h0, m_irq_en, 1'b1};
    for (int c = 0; c < 20; c++) begin
      bus.st_valid = 1'b1;
      bus.st_addr  = $urandom;
      bus.st_data  = {$urandom, $urandom};
      e = exp_reg(2'd3);
      void'(q.pop_front());
      q.push_back({bus.st_addr, bus.st_data});
      tick();
      checks++;
      if (bus.readdata !== e || bus.readdata[15:8] !== 8'd3) begin
        errors++;
        $display("FAIL stream_count cycle=%0d actual=%h required=%h", c, bus.readdata, e);
      end
    end
    idle_bus();
    while (q.size() != 0) begin
      for (int a = 0; a < 3; a++) begin
        rd(2'(a), d);
        checks++;
        if (d !== exp_reg(2'(a))) begin
          errors++;
          $display("FAIL stream_order_addr%0d actual=%h required=%h", a, d, exp_reg(2'(a)));
        end
      end
      pop();
    end
  endtask

  task automatic test_random();
    logic        v;
    logic        w;
    logic [1:0]  a;
    logic [31:0] wd;
    logic [31:0] e_rd;
    logic        e_irq;
    logic        e_ready;
    logic [95:0] ent;
    for (int c = 0; c < 300; c++) begin
      v  = ($urandom_range(0, 2) != 0);
      a  = 2'($urandom_range(0, 3));
      w  = ($urandom_range(0, 2) == 0);
      wd = $urandom;
      ent = {$urandom, $urandom, $urandom};
      bus.st_valid  = v;
      bus.st_addr   = ent[95:64];
      bus.st_data   = ent[63:0];
      bus.address   = a;
      bus.write     = w;
      bus.read      = !w;
      bus.writedata = wd;
      e_ready = (q.size() != DEPTH);
      checks++;
      if (bus.st_ready !== e_ready) begin
        errors++;
        $display("FAIL rand_ready cycle=%0d actual=%b required=%b", c, bus.st_ready, e_ready);
      end
      e_rd  = exp_reg(a);
      e_irq = m_irq_en && (q.size() != 0);
      if (w && a == 2'd3) begin
        if (wd[0] && q.size() != 0) void'(q.pop_front());
        m_irq_en = wd[1];
      end
      if (v && e_ready) q.push_back(ent);
      tick();
      checks++;
      if (bus.readdata !== e_rd || bus.irq !== e_irq) begin
        errors++;
        $display("FAIL rand_read cycle=%0d addr=%0d readdata=%h irq=%b required %h/%b",
                 c, a, bus.readdata, bus.irq, e_rd, e_irq);
      end
    end
    idle_bus();
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    ctrl_write(32'h2);
    for (int i = 0; i < 4; i++) push($urandom, {$urandom, $urandom});
    bus.address = 2'd3;
    tick();
    checks++;
    if (bus.irq !== 1'b1 || bus.readdata !== exp_reg(2'd3)) begin
      errors++;
      $display("FAIL pre_reset irq=%b status=%h required 1/%h", bus.irq, bus.readdata, exp_reg(2'd3));
    end
    bus.st_valid = 1'b1;
    bus.st_addr  = $urandom;
    bus.st_data  = {$urandom, $urandom};
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if (bus.readdata !== 32'h0 || bus.irq !== 1'b0 || bus.st_ready !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset readdata=%h irq=%b st_ready=%b required 0/0/1",
               bus.readdata, bus.irq, bus.st_ready);
    end
    q.delete();
    m_irq_en = 1'b0;
    idle_bus();
    tick();
    reset_n = 1'b1;
    tick();
    rd(2'd3, d);
    checks++;
    if (d !== 32'h0) begin
      errors++;
      $display("FAIL post_reset_status actual=%h required=00000000", d);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_full();
    test_empty_pop();
    test_irq();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
